// File: rtl/timer_display_driver_if.sv
// Time-field and display-pin bundle between the countdown timer and the 7-segment driver.
// master: timer/top side driving the time fields and blank; slave: the display driver.
interface timer_display_driver_if;
    logic [4:0] hour_in;
    logic [5:0] min_in;
    logic [5:0] sec_in;
    logic       blank;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (output hour_in, min_in, sec_in, blank, input an, seg, dp);
    modport slave  (input hour_in, min_in, sec_in, blank, output an, seg, dp);
endinterface

// File: rtl/timer_display_driver.sv
// Scans HH.MM.SS onto an 8-digit common-anode 7-segment display, snapshotting the time once per frame.
// Optional macro LEADING_ZERO_BLANK_EN: blank the hour tens digit when it is zero.
module timer_display_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 17
) (
    input  logic                 clk,
    input  logic                 reset,
    timer_display_driver_if.slave disp
);
    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    logic [CNT_W-1:0] prescaler;
    logic [2:0]       digit_idx;
    logic [4:0]       snap_hour;
    logic [5:0]       snap_min;
    logic [5:0]       snap_sec;
    logic             tick;

    logic [7:0] an_q, an_next;
    logic [6:0] seg_q, seg_next;
    logic       dp_q, dp_next;

    logic [3:0] hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones;
    logic       hour_bad, min_bad, sec_bad;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = SEG_OFF;
        endcase
    endfunction

    assign tick = (prescaler == CNT_W'(REFRESH_DIV - 1));

    // The snapshot only moves at the frame boundary so no digit tears mid-frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            digit_idx <= 3'd0;
            snap_hour <= 5'd0;
            snap_min  <= 6'd0;
            snap_sec  <= 6'd0;
        end else if (tick) begin
            prescaler <= '0;
            digit_idx <= digit_idx + 3'd1;
            if (digit_idx == 3'd7) begin
                snap_hour <= disp.hour_in;
                snap_min  <= disp.min_in;
                snap_sec  <= disp.sec_in;
            end
        end else begin
            prescaler <= prescaler + CNT_W'(1);
        end
    end

    assign hour_tens = 4'(snap_hour / 5'd10);
    assign hour_ones = 4'(snap_hour % 5'd10);
    assign min_tens  = 4'(snap_min / 6'd10);
    assign min_ones  = 4'(snap_min % 6'd10);
    assign sec_tens  = 4'(snap_sec / 6'd10);
    assign sec_ones  = 4'(snap_sec % 6'd10);

    assign hour_bad = (snap_hour > 5'd23);
    assign min_bad  = (snap_min > 6'd59);
    assign sec_bad  = (snap_sec > 6'd59);

    always_comb begin
        an_next  = 8'hFF;
        seg_next = SEG_OFF;
        case (digit_idx)
            3'd0: begin an_next = 8'hFE; seg_next = sec_bad  ? SEG_DASH : seg_code(sec_ones);  end
            3'd1: begin an_next = 8'hFD; seg_next = sec_bad  ? SEG_DASH : seg_code(sec_tens);  end
            3'd2: begin an_next = 8'hFB; seg_next = min_bad  ? SEG_DASH : seg_code(min_ones);  end
            3'd3: begin an_next = 8'hF7; seg_next = min_bad  ? SEG_DASH : seg_code(min_tens);  end
            3'd4: begin an_next = 8'hEF; seg_next = hour_bad ? SEG_DASH : seg_code(hour_ones); end
            3'd5: begin
                an_next  = 8'hDF;
                seg_next = hour_bad ? SEG_DASH : seg_code(hour_tens);
`ifdef LEADING_ZERO_BLANK_EN
                if (!hour_bad && hour_tens == 4'd0)
                    seg_next = SEG_OFF;
`endif
            end
            default: begin an_next = 8'hFF; seg_next = SEG_OFF; end
        endcase
        dp_next = !((digit_idx == 3'd2) || (digit_idx == 3'd4));
    end

    // blank only gates the anodes; segment data keeps tracking the scan.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_q  <= 8'hFF;
            seg_q <= SEG_OFF;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= disp.blank ? 8'hFF : an_next;
            seg_q <= seg_next;
            dp_q  <= dp_next;
        end
    end

    assign disp.an  = an_q;
    assign disp.seg = seg_q;
    assign disp.dp  = dp_q;
endmodule

// File: tb/tb_timer_display_driver.sv
// Directed bench for timer_display_driver with REFRESH_DIV=4 (one digit slot = 4 clk).
module tb_timer_display_driver;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    timer_display_driver_if dif();

    timer_display_driver #(.REFRESH_DIV(4), .CNT_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .disp  (dif)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S6 = 7'b0000010, S7 = 7'b1111000;
    localparam logic [6:0] DASH = 7'b0111111, OFF = 7'h7F;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] an_exp [8];
        logic [6:0] seg_f2 [6];
        logic [6:0] seg_f4 [6];
        an_exp = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hFF, 8'hFF};
        seg_f2 = '{S6, S5, S4, S3, S2, S1};
        seg_f4 = '{DASH, DASH, S5, S0, DASH, DASH};

        dif.hour_in = 5'd0;
        dif.min_in  = 6'd0;
        dif.sec_in  = 6'd0;
        dif.blank   = 1'b0;

        // 1: reset values, then one full frame of 00.00.00
        #12;
        check("rst_an", dif.an, 8'hFF);
        check("rst_seg", {1'b0, dif.seg}, {1'b0, OFF});
        check("rst_dp", {7'd0, dif.dp}, 8'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 8; d++) begin
            if (d > 0) repeat (4) @(negedge clk);
            check($sformatf("f1_an_d%0d", d), dif.an, an_exp[d]);
            check($sformatf("f1_seg_d%0d", d), {1'b0, dif.seg}, {1'b0, (d < 6) ? S0 : OFF});
            check($sformatf("f1_dp_d%0d", d), {7'd0, dif.dp}, {7'd0, !(d == 2 || d == 4)});
            // 2: new time arrives mid-frame; remaining digits of this frame must still read 0
            if (d == 2) begin
                dif.hour_in = 5'd12;
                dif.min_in  = 6'd34;
                dif.sec_in  = 6'd56;
            end
        end

        // 2: next frame shows 12.34.56
        repeat (4) @(negedge clk);
        for (int d = 0; d < 6; d++) begin
            if (d > 0) repeat (4) @(negedge clk);
            check($sformatf("f2_an_d%0d", d), dif.an, an_exp[d]);
            check($sformatf("f2_seg_d%0d", d), {1'b0, dif.seg}, {1'b0, seg_f2[d]});
            check($sformatf("f2_dp_d%0d", d), {7'd0, dif.dp}, {7'd0, !(d == 2 || d == 4)});
            if (d == 2) dif.sec_in = 6'd55;
        end

        // 3: sec change picked up at the following frame
        repeat (12) @(negedge clk);
        check("f3_an_d0", dif.an, 8'hFE);
        check("f3_seg_d0", {1'b0, dif.seg}, {1'b0, S5});

        // 4: out-of-range hour and sec show dashes
        dif.hour_in = 5'd30;
        dif.min_in  = 6'd5;
        dif.sec_in  = 6'd60;
        repeat (32) @(negedge clk);
        for (int d = 0; d < 6; d++) begin
            if (d > 0) repeat (4) @(negedge clk);
            check($sformatf("f4_an_d%0d", d), dif.an, an_exp[d]);
            check($sformatf("f4_seg_d%0d", d), {1'b0, dif.seg}, {1'b0, seg_f4[d]});
        end

        // 5: blank for 10 clk while digit 5 is shown
        dif.blank = 1'b1;
        @(negedge clk);
        check("blank_an", dif.an, 8'hFF);
        check("blank_seg", {1'b0, dif.seg}, {1'b0, DASH});
        repeat (9) @(negedge clk);
        dif.blank = 1'b0;
        repeat (2) @(negedge clk);
        check("unblank_an_d0", dif.an, 8'hFE);
        check("unblank_seg_d0", {1'b0, dif.seg}, {1'b0, DASH});
        repeat (4) @(negedge clk);
        check("unblank_an_d1", dif.an, 8'hFD);

        // 6: 7:05:09, hour tens handling
        dif.hour_in = 5'd7;
        dif.min_in  = 6'd5;
        dif.sec_in  = 6'd9;
        repeat (44) @(negedge clk);
        check("h7_an_d4", dif.an, 8'hEF);
        check("h7_seg_d4", {1'b0, dif.seg}, {1'b0, S7});
        check("h7_dp_d4", {7'd0, dif.dp}, 8'd0);
        repeat (4) @(negedge clk);
        check("h7_an_d5", dif.an, 8'hDF);
`ifdef LEADING_ZERO_BLANK_EN
        check("h7_seg_d5", {1'b0, dif.seg}, {1'b0, OFF});
`else
        check("h7_seg_d5", {1'b0, dif.seg}, {1'b0, S0});
`endif

        // async reset mid-scan, no clock edge needed
        #2;
        reset = 1'b1;
        #1;
        check("arst_an", dif.an, 8'hFF);
        check("arst_seg", {1'b0, dif.seg}, {1'b0, OFF});
        check("arst_dp", {7'd0, dif.dp}, 8'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("restart_an", dif.an, 8'hFE);
        check("restart_seg", {1'b0, dif.seg}, {1'b0, S0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
